// File: rtl/bmp_frame_arbiter_pkg.sv
// bmp_pkg: shared FSM state type, mode encodings and header layout
// constants for the BMP frame arbiter.
package bmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_e;

  localparam logic [1:0] MODE_TH  = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;

  localparam int HEADER_BYTES = 56;

  // The 32-bit file size sits in header bytes 2..5 (little-endian). With
  // byte 0 of each word in [31:24], it straddles beat 0 and beat 1.
  localparam int FSIZE_LO_BEAT = 0;
  localparam int FSIZE_HI_BEAT = 1;

  function automatic logic mode_is_request(input logic [1:0] mode);
    return (mode == MODE_TH) || (mode == MODE_BYP);
  endfunction

  // w0_lo holds [15:0] of beat 0 (bytes 2,3); w1 is beat 1 (bytes 4,5 on top).
  function automatic logic [31:0] parse_file_size(input logic [15:0] w0_lo,
                                                  input logic [31:0] w1);
    return {w1[23:16], w1[31:24], w0_lo[7:0], w0_lo[15:8]};
  endfunction

endpackage

// File: rtl/bmp_frame_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter. Grant is combinational from req;
// the winner is remembered only when update is strobed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // Reset value 1 (slv1 won last) so slv0 wins the first contention.
  logic last_winner_q, last_winner_d;

  // On contention pick the side that did not win last; otherwise pass req.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_winner_q ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner only when the caller commits the grant.
  always_comb begin
    last_winner_d = last_winner_q;
    if (update && (grant != 2'b00)) begin
      last_winner_d = grant[1];
    end
  end

  // Winner history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner_q <= 1'b1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

endmodule

// File: rtl/bmp_frame_arbiter.sv
// bmp_frame_arbiter: locks the BMP datapath to one slave for a whole file
// (header through last pixel word), then idles DEAD_TIME cycles before
// re-arbitrating round-robin.
// Optional stall watchdog: define BMP_ARB_TIMEOUT_EN.
module bmp_frame_arbiter #(
  parameter int DATA_BUS_SIZE  = 32,
  parameter int HEADER_BYTES   = 56,
  parameter int DEAD_TIME      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               slv0_mode,
  input  logic [1:0]               slv1_mode,
  input  logic                     slv0_data_valid,
  input  logic                     slv1_data_valid,
  input  logic [DATA_BUS_SIZE-1:0] slv0_data,
  input  logic [DATA_BUS_SIZE-1:0] slv1_data,
  output logic                     slv0_ready,
  output logic                     slv1_ready,
  input  logic                     mstr0_ready,
  output logic [DATA_BUS_SIZE-1:0] arb_data,
  output logic                     arb_data_valid,
  output logic [1:0]               arb_mode,
  output logic [1:0]               arb_grant,
  output logic                     hdr_phase,
  output logic [31:0]              file_size,
  output logic                     frame_done,
  output logic                     timeout_err
);
  import bmp_pkg::*;

  localparam int BEAT_BYTES = DATA_BUS_SIZE / 8;

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] file_size_q, file_size_d;
  logic [15:0] w0_lo_q, w0_lo_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        frame_done_q, frame_done_d;

  logic [1:0]  eligible;
  logic [1:0]  rr_grant;
  logic        rr_update;
  logic        sel_valid;
  logic        in_frame;
  logic        beat;
  logic [31:0] byte_cnt_inc;

  assign eligible  = {mode_is_request(slv1_mode) & slv1_data_valid,
                      mode_is_request(slv0_mode) & slv0_data_valid};
  assign rr_update = (state_q == ST_IDLE) && (eligible != 2'b00);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (eligible),
    .update (rr_update),
    .grant  (rr_grant)
  );

  // Zero-latency mux of the owner's word and valid; zero when nobody owns.
  always_comb begin
    arb_data  = '0;
    sel_valid = 1'b0;
    if (grant_q[0]) begin
      arb_data  = slv0_data;
      sel_valid = slv0_data_valid;
    end else if (grant_q[1]) begin
      arb_data  = slv1_data;
      sel_valid = slv1_data_valid;
    end
  end

  assign in_frame     = (state_q == ST_HEADER) || (state_q == ST_BODY);
  assign beat         = in_frame & sel_valid & mstr0_ready;
  assign byte_cnt_inc = byte_cnt_q + 32'(BEAT_BYTES);

`ifdef BMP_ARB_TIMEOUT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        stall_expired;

  assign stall_expired = in_frame && !beat &&
                         (stall_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts frame cycles without a beat, cleared by a beat or a new grant.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = 1'b0;
    if (rr_update) begin
      stall_cnt_d = '0;
    end else if (in_frame) begin
      stall_cnt_d   = (beat || stall_expired) ? '0 : stall_cnt_q + 32'd1;
      timeout_err_d = stall_expired;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  // Frame ownership FSM: grant, header parse, byte count, release and dead time.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mode_d       = mode_q;
    byte_cnt_d   = byte_cnt_q;
    file_size_d  = file_size_q;
    w0_lo_d      = w0_lo_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_update) begin
          state_d    = ST_HEADER;
          grant_d    = rr_grant;
          mode_d     = rr_grant[0] ? slv0_mode : slv1_mode;
          byte_cnt_d = '0;
        end
      end

      ST_HEADER, ST_BODY: begin
        if (beat) begin
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_q == 32'(FSIZE_LO_BEAT * BEAT_BYTES)) begin
            w0_lo_d = arb_data[15:0];
          end
          if (byte_cnt_q == 32'(FSIZE_HI_BEAT * BEAT_BYTES)) begin
            file_size_d = parse_file_size(w0_lo_q, arb_data[31:0]);
          end
          // A file no longer than the header ends with the header itself.
          if (((state_q == ST_HEADER) && (byte_cnt_inc == 32'(HEADER_BYTES)) &&
               (file_size_q <= 32'(HEADER_BYTES))) ||
              ((state_q == ST_BODY) && (byte_cnt_inc >= file_size_q))) begin
            state_d      = ST_GAP;
            grant_d      = '0;
            gap_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else if ((state_q == ST_HEADER) && (byte_cnt_inc == 32'(HEADER_BYTES))) begin
            state_d = ST_BODY;
          end
        end
`ifdef BMP_ARB_TIMEOUT_EN
        else if (stall_expired) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          gap_cnt_d = '0;
        end
`endif
      end

      ST_GAP: begin
        if (gap_cnt_q >= 16'(DEAD_TIME - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      mode_q       <= '0;
      byte_cnt_q   <= '0;
      file_size_q  <= '0;
      w0_lo_q      <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mode_q       <= mode_d;
      byte_cnt_q   <= byte_cnt_d;
      file_size_q  <= file_size_d;
      w0_lo_q      <= w0_lo_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign slv0_ready     = grant_q[0] & mstr0_ready;
  assign slv1_ready     = grant_q[1] & mstr0_ready;
  assign arb_data_valid = sel_valid & in_frame;
  assign arb_mode       = mode_q;
  assign arb_grant      = grant_q;
  assign hdr_phase      = (state_q == ST_HEADER);
  assign file_size      = file_size_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_bmp_frame_arbiter.sv
// Testbench for bmp_frame_arbiter: per-cycle comparison against a
// frame-level reference model (owner, beats-per-file, dead-time window).
module tb_bmp_frame_arbiter;

  localparam int DT = 3;
  localparam int TO = 16;
  localparam int HB = 56;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  slv0_mode, slv1_mode;
  logic        slv0_data_valid, slv1_data_valid;
  logic [31:0] slv0_data, slv1_data;
  logic        slv0_ready, slv1_ready;
  logic        mstr0_ready;
  logic [31:0] arb_data;
  logic        arb_data_valid;
  logic [1:0]  arb_mode;
  logic [1:0]  arb_grant;
  logic        hdr_phase;
  logic [31:0] file_size;
  logic        frame_done;
  logic        timeout_err;

  always #5 clk = ~clk;

  bmp_frame_arbiter #(
    .DATA_BUS_SIZE  (32),
    .HEADER_BYTES   (HB),
    .DEAD_TIME      (DT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .slv0_mode       (slv0_mode),
    .slv1_mode       (slv1_mode),
    .slv0_data_valid (slv0_data_valid),
    .slv1_data_valid (slv1_data_valid),
    .slv0_data       (slv0_data),
    .slv1_data       (slv1_data),
    .slv0_ready      (slv0_ready),
    .slv1_ready      (slv1_ready),
    .mstr0_ready     (mstr0_ready),
    .arb_data        (arb_data),
    .arb_data_valid  (arb_data_valid),
    .arb_mode        (arb_mode),
    .arb_grant       (arb_grant),
    .hdr_phase       (hdr_phase),
    .file_size       (file_size),
    .frame_done      (frame_done),
    .timeout_err     (timeout_err)
  );

  int checks = 0;
  int fails  = 0;

  // Stimulus state per slave
  bit          act [2];
  bit          rv  [2];
  logic [1:0]  md  [2];
  int          fsz [2];
  logic [31:0] fw  [2][128];
  int          widx[2];
  int          frames[2];
  bit          v   [2];
  bit          rdy;
  bit          rrdy, mchg;

  // Reference model
  int          owner, beats, total, lw, idle_at, cyc, stall;
  logic [1:0]  exp_mode;
  logic [31:0] mfs;
  bit          exp_fd, exp_to;
  int          last_fd_cyc, obs_beats, to_count;
  bit          chk_gap, log_en;
  logic [1:0]  prev_grant;
  int          glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int total_beats(input int fs);
    int t;
    t = (fs + 3) / 4;
    return (t < HB / 4) ? HB / 4 : t;
  endfunction

  task automatic refill(input int s);
    logic [31:0] f;
    f = 32'(fsz[s]);
    fw[s][0] = {8'h42, 8'h4D, f[7:0], f[15:8]};
    fw[s][1] = {f[23:16], f[31:24], 16'($urandom)};
    for (int k = 2; k < 128; k++) fw[s][k] = $urandom;
    widx[s] = 0;
  endtask

  task automatic drive();
    slv0_mode       = md[0];
    slv1_mode       = md[1];
    slv0_data_valid = v[0];
    slv1_data_valid = v[1];
    slv0_data       = fw[0][widx[0]];
    slv1_data       = fw[1][widx[1]];
    mstr0_ready     = rdy;
  endtask

  // One clock cycle: drive, compare every output with the model, advance model.
  task automatic step();
    bit e0, e1;
    int w, o;
    logic [1:0] eg;
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    for (int s = 0; s < 2; s++) v[s] = act[s] && (!rv[s] || ($urandom_range(0, 1) == 1));
    if (mchg) md[1] = (owner == 1) ? 2'($urandom_range(0, 3)) : 2'b01;
    rdy = rrdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    drive();
    #1;
    eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    chk("arb_grant", 32'(arb_grant), 32'(eg));
    chk("slv0_ready", 32'(slv0_ready), 32'((owner == 0) && rdy));
    chk("slv1_ready", 32'(slv1_ready), 32'((owner == 1) && rdy));
    chk("arb_data", arb_data, (owner >= 0) ? fw[owner][widx[owner]] : 32'd0);
    chk("arb_data_valid", 32'(arb_data_valid), 32'((owner >= 0) && v[owner]));
    chk("hdr_phase", 32'(hdr_phase), 32'((owner >= 0) && (beats < HB / 4)));
    chk("arb_mode", 32'(arb_mode), 32'(exp_mode));
    chk("file_size", file_size, mfs);
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    if (arb_data_valid && mstr0_ready) obs_beats++;
    if (frame_done) last_fd_cyc = cyc;
    if (chk_gap && (prev_grant == 2'b00) && (arb_grant != 2'b00) && (last_fd_cyc >= 0))
      chk("fd_to_grant", 32'(cyc - last_fd_cyc), 32'(DT + 1));
    prev_grant = arb_grant;

    exp_fd = 1'b0;
    exp_to = 1'b0;
    if (owner < 0) begin
      if (cyc >= idle_at) begin
        e0 = v[0] && ((md[0] == 2'b01) || (md[0] == 2'b10));
        e1 = v[1] && ((md[1] == 2'b01) || (md[1] == 2'b10));
        if (e0 || e1) begin
          w        = (e0 && e1) ? (1 - lw) : (e0 ? 0 : 1);
          lw       = w;
          owner    = w;
          beats    = 0;
          stall    = 0;
          total    = total_beats(fsz[w]);
          exp_mode = md[w];
          if (log_en) glog.push_back(w);
        end
      end
    end else begin
      o = owner;
      if (v[o] && rdy) begin
        beats++;
        widx[o]++;
        stall = 0;
        if (beats == 2) mfs = 32'(fsz[o]);
        if (beats == total) begin
          exp_fd  = 1'b1;
          frames[o]++;
          refill(o);
          owner   = -1;
          idle_at = cyc + 1 + DT;
        end
      end else begin
`ifdef BMP_ARB_TIMEOUT_EN
        stall++;
        if (stall == TO) begin
          exp_to  = 1'b1;
          to_count++;
          refill(o);
          owner   = -1;
          idle_at = cyc + 1 + DT;
        end
`endif
      end
    end
  endtask

  // Hold reset for one cycle; outputs must be zero while it is asserted.
  task automatic reset_cycle();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    #1;
    chk("rst_grant", 32'(arb_grant), 32'd0);
    chk("rst_ready", 32'({slv1_ready, slv0_ready}), 32'd0);
    chk("rst_data", arb_data, 32'd0);
    chk("rst_valid", 32'(arb_data_valid), 32'd0);
    chk("rst_mode", 32'(arb_mode), 32'd0);
    chk("rst_hdr", 32'(hdr_phase), 32'd0);
    chk("rst_fsize", file_size, 32'd0);
    chk("rst_done", 32'({timeout_err, frame_done}), 32'd0);
    owner = -1; lw = 1; beats = 0; stall = 0;
    mfs = '0; exp_mode = '0; exp_fd = 1'b0; exp_to = 1'b0;
    prev_grant = 2'b00;
    refill(0); refill(1);
    idle_at = cyc + 1;
  endtask

  task automatic run_frames(input int s, input int n, input int budget);
    int start, k;
    start = frames[s];
    k = 0;
    while ((frames[s] - start < n) && (k < budget)) begin step(); k++; end
    chk("frames_in_budget", 32'(frames[s] - start), 32'(n));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int k, eb, tc;
    rst = 1'b1;
    cyc = 0; owner = -1; lw = 1; idle_at = 0; last_fd_cyc = -1;
    obs_beats = 0; to_count = 0; chk_gap = 0; log_en = 0;
    rrdy = 0; mchg = 0; rdy = 1; prev_grant = 2'b00;
    for (int s = 0; s < 2; s++) begin
      act[s] = 0; rv[s] = 0; md[s] = 2'b00; fsz[s] = 0; frames[s] = 0; v[s] = 0;
      refill(s);
    end
    drive();
    reset_cycle();
    reset_cycle();

    // Single frame: slv0 bypass, 128-byte file
    md[0] = 2'b10; fsz[0] = 128; refill(0); act[0] = 1; obs_beats = 0;
    run_frames(0, 1, 200);
    act[0] = 0;
    step();
    chk("single_fsize", file_size, 32'd128);
    chk("single_beats", 32'(obs_beats), 32'd32);
    idle_steps(DT + 2);

    // Short file: header declares 40 bytes, frame still spans the header
    md[1] = 2'b01; fsz[1] = 40; refill(1); act[1] = 1; obs_beats = 0;
    run_frames(1, 1, 200);
    act[1] = 0;
    step();
    chk("short_fsize", file_size, 32'd40);
    chk("short_beats", 32'(obs_beats), 32'd14);
    idle_steps(DT + 2);

    // Contention: both request continuously
    md[0] = 2'b10; md[1] = 2'b01; fsz[0] = 100; fsz[1] = 72;
    refill(0); refill(1);
    glog.delete(); log_en = 1; chk_gap = 1; last_fd_cyc = -1;
    act[0] = 1; act[1] = 1;
    k = frames[0] + frames[1];
    tc = 0;
    while ((frames[0] + frames[1] - k < 3) && (tc < 600)) begin step(); tc++; end
    chk("cont_frames", 32'(frames[0] + frames[1] - k), 32'd3);
    chk("cont_grants", 32'(glog.size()), 32'd3);
    if (glog.size() >= 3) begin
      chk("cont_order0", 32'(glog[0]), 32'd0);
      chk("cont_order1", 32'(glog[1]), 32'd1);
      chk("cont_order2", 32'(glog[2]), 32'd0);
    end
    act[0] = 0; act[1] = 0;
    idle_steps(DT + 3);
    log_en = 0; chk_gap = 0;

    // Backpressure on slv1 with random valid/ready and mid-frame mode churn
    rv[1] = 1; rrdy = 1; mchg = 1; act[1] = 1;
    for (int f = 0; f < 2; f++) begin
      fsz[1] = $urandom_range(57, 400); refill(1);
      eb = total_beats(fsz[1]);
      obs_beats = 0; tc = to_count;
      run_frames(1, 1, 4000);
      act[1] = 0;
      step();
      if (to_count == tc) chk("bp_beats", 32'(obs_beats), 32'(eb));
      chk("bp_fsize", file_size, 32'(fsz[1]));
      idle_steps(DT + 2);
      act[1] = 1;
    end
    act[1] = 0; rv[1] = 0; rrdy = 0; mchg = 0;
    idle_steps(DT + 2);

    // Reset mid-BODY, then slv0 must win the first contention again
    md[0] = 2'b10; md[1] = 2'b01; fsz[0] = 200; fsz[1] = 100;
    refill(0); refill(1);
    act[0] = 1; act[1] = 1;
    tc = 0;
    while (!((owner == 0) && (beats >= 20)) && (tc < 200)) begin step(); tc++; end
    chk("reached_body", 32'((owner == 0) && (beats >= 20)), 32'd1);
    reset_cycle();
    tc = 0;
    step();
    while ((arb_grant == 2'b00) && (tc < 20)) begin step(); tc++; end
    chk("first_grant_after_reset", 32'(arb_grant), 32'd1);
    run_frames(0, 1, 300);
    act[0] = 0; act[1] = 0;
    idle_steps(DT + 3);

`ifdef BMP_ARB_TIMEOUT_EN
    // Stall after beat 20: watchdog fires, grant drops, no frame_done
    md[0] = 2'b10; fsz[0] = 200; refill(0); act[0] = 1;
    tc = 0;
    while (!((owner == 0) && (beats >= 20)) && (tc < 200)) begin step(); tc++; end
    chk("to_reached_beat20", 32'(beats), 32'd20);
    act[0] = 0;
    tc = to_count;
    idle_steps(TO);
    chk("to_grant_held", 32'(arb_grant), 32'd1);
    step();
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_grant_dropped", 32'(arb_grant), 32'd0);
    chk("to_no_frame_done", 32'(frame_done), 32'd0);
    chk("to_model_fired", 32'(to_count - tc), 32'd1);
    idle_steps(DT + 3);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
